// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter for the I-cache and D-cache miss handlers.
// Serves block fills for either cache and D-cache store-through writes, with D given fixed priority.
module mem_arbiter #(
  parameter int AWIDTH    = 16,
  parameter int DWIDTH    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [AWIDTH-1:0]            i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [AWIDTH-1:0]            d_addr,
  input  logic [DWIDTH-1:0]            d_wdata,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [AWIDTH-1:0]            mem_addr,
  output logic [DWIDTH-1:0]            mem_wdata,
  input  logic [DWIDTH-1:0]            mem_rdata,
  input  logic                         mem_valid,
  output logic [DWIDTH-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic                         i_fill_we,
  output logic                         d_fill_we,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         busy
);

  localparam int                CW        = $clog2(BLK_WORDS);
  localparam logic [CW:0]       ISSUE_END = (CW+1)'(BLK_WORDS);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(BLK_WORDS-1);
  // Byte addresses of 16-bit words: a block spans 2*BLK_WORDS bytes.
  localparam logic [AWIDTH-1:0] BLK_MASK  = ~AWIDTH'(2*BLK_WORDS-1);

  typedef enum logic [1:0] {IDLE, FILL, STORE, DONE} state_t;

  state_t              state, state_nxt;
  logic                owner;
  logic [AWIDTH-1:0]   base;
  logic [AWIDTH-1:0]   st_addr;
  logic [DWIDTH-1:0]   st_wdata;
  logic [CW:0]         ic;
  logic [CW-1:0]       rc;
  logic                issuing;

  assign issuing = (state == FILL) && (ic < ISSUE_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)      state_nxt = d_wr ? STORE : FILL;
        else if (i_req) state_nxt = FILL;
      end
      FILL:    if (mem_valid && rc == LAST_BEAT) state_nxt = DONE;
      STORE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture and the issue/receive counters; requests outside IDLE are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      base     <= '0;
      st_addr  <= '0;
      st_wdata <= '0;
      ic       <= '0;
      rc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          ic <= '0;
          rc <= '0;
          if (d_req) begin
            owner <= 1'b1;
            if (d_wr) begin
              st_addr  <= d_addr;
              st_wdata <= d_wdata;
            end else begin
              base <= d_addr & BLK_MASK;
            end
          end else if (i_req) begin
            owner <= 1'b0;
            base  <= i_addr & BLK_MASK;
          end
        end
        FILL: begin
          if (issuing)   ic <= ic + 1'b1;
          if (mem_valid) rc <= rc + 1'b1;
        end
        DONE: begin
          ic <= '0;
          rc <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_data = '0;
    fill_word = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = base + AWIDTH'({ic[CW-1:0], 1'b0});
        end
        // Beats go straight through to the owning cache in the cycle they arrive.
        if (mem_valid) begin
          fill_data = mem_rdata;
          fill_word = rc;
          i_fill_we = ~owner;
          d_fill_we = owner;
        end
      end
      STORE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = st_addr;
        mem_wdata = st_wdata;
      end
      DONE: begin
        i_done = ~owner;
        d_done = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined read memory model.
// Read data is address ^ 16'hA5A5 so every beat's contents are predictable.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] obs_addr[$];
  int          obs_icyc[$];
  logic [2:0]  obs_word[$];
  logic [15:0] obs_data[$];
  int          obs_i_we, obs_d_we, obs_wr, done_cyc;
  logic        obs_i_done, obs_d_done;

  logic [3:0]  pv;
  logic [15:0] pa [4];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read returns 4 cycles after issue; reset flushes anything in flight.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign mem_valid = pv[3];
  assign mem_rdata = pa[3] ^ 16'hA5A5;

  // Records one transaction starting the cycle after acceptance; drops the req that sees done.
  task automatic observe(input int max_cyc);
    obs_addr.delete(); obs_icyc.delete(); obs_word.delete(); obs_data.delete();
    obs_i_we = 0; obs_d_we = 0; obs_wr = 0; done_cyc = -1;
    obs_i_done = 1'b0; obs_d_done = 1'b0;
    for (int cyc = 1; cyc <= max_cyc && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (mem_en) begin
        obs_addr.push_back(mem_addr);
        obs_icyc.push_back(cyc);
        if (mem_wr) obs_wr++;
      end
      if (i_fill_we) obs_i_we++;
      if (d_fill_we) obs_d_we++;
      if (i_fill_we || d_fill_we) begin
        obs_word.push_back(fill_word);
        obs_data.push_back(fill_data);
      end
      if (i_done || d_done) begin
        done_cyc   = cyc;
        obs_i_done = i_done;
        obs_d_done = d_done;
        if (i_done) i_req = 1'b0;
        if (d_done) d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_en got %b want 0", mem_en); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_mem_addr got %h want 0000", mem_addr); end
    n_cmp++; if ({i_done, d_done, i_fill_we, d_fill_we} !== 4'b0) begin n_bad++; $display("[TB] FAIL reset_flags got %b want 0000", {i_done, d_done, i_fill_we, d_fill_we}); end
    rst = 1'b0;
  endtask

  task automatic test_i_fill();
    @(posedge clk); @(negedge clk);
    i_addr = 16'h1236; i_req = 1'b1;
    @(posedge clk);
    observe(20);
    n_cmp++; if (done_cyc !== 13) begin n_bad++; $display("[TB] FAIL ifill_latency got %0d want 13", done_cyc); end
    n_cmp++; if ({obs_i_done, obs_d_done} !== 2'b10) begin n_bad++; $display("[TB] FAIL ifill_done_owner got %b want 10", {obs_i_done, obs_d_done}); end
    n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("[TB] FAIL ifill_issue_count got %0d want 8", obs_addr.size()); end
    for (int k = 0; k < 8 && k < obs_addr.size(); k++) begin
      n_cmp++; if (obs_addr[k] !== 16'h1230 + 16'(2*k)) begin n_bad++; $display("[TB] FAIL ifill_addr[%0d] got %h want %h", k, obs_addr[k], 16'h1230 + 16'(2*k)); end
      n_cmp++; if (obs_icyc[k] !== k + 1) begin n_bad++; $display("[TB] FAIL ifill_issue_cyc[%0d] got %0d want %0d", k, obs_icyc[k], k + 1); end
    end
    n_cmp++; if (obs_i_we !== 8) begin n_bad++; $display("[TB] FAIL ifill_i_we got %0d want 8", obs_i_we); end
    n_cmp++; if (obs_d_we !== 0) begin n_bad++; $display("[TB] FAIL ifill_d_we got %0d want 0", obs_d_we); end
    for (int k = 0; k < 8 && k < obs_word.size(); k++) begin
      n_cmp++; if (obs_word[k] !== 3'(k)) begin n_bad++; $display("[TB] FAIL ifill_word[%0d] got %0d want %0d", k, obs_word[k], k); end
      n_cmp++; if (obs_data[k] !== ((16'h1230 + 16'(2*k)) ^ 16'hA5A5)) begin n_bad++; $display("[TB] FAIL ifill_data[%0d] got %h want %h", k, obs_data[k], (16'h1230 + 16'(2*k)) ^ 16'hA5A5); end
    end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL ifill_idle_after got busy=%b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    @(posedge clk); @(negedge clk);
    i_addr = 16'h0010; i_req = 1'b1;
    d_addr = 16'h8000; d_wr = 1'b0; d_req = 1'b1;
    @(posedge clk);
    observe(20);
    n_cmp++; if ({obs_i_done, obs_d_done} !== 2'b01) begin n_bad++; $display("[TB] FAIL simul_first_owner got %b want 01", {obs_i_done, obs_d_done}); end
    n_cmp++; if (obs_d_we !== 8 || obs_i_we !== 0) begin n_bad++; $display("[TB] FAIL simul_d_beats got d=%0d i=%0d want d=8 i=0", obs_d_we, obs_i_we); end
    n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("[TB] FAIL simul_d_issue_count got %0d want 8", obs_addr.size()); end
    for (int k = 0; k < 8 && k < obs_addr.size(); k++) begin
      n_cmp++; if (obs_addr[k] !== 16'h8000 + 16'(2*k)) begin n_bad++; $display("[TB] FAIL simul_d_addr[%0d] got %h want %h", k, obs_addr[k], 16'h8000 + 16'(2*k)); end
    end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("[TB] FAIL simul_idle_gap got busy=%b mem_en=%b want 0 0", busy, mem_en); end
    @(posedge clk);
    observe(20);
    n_cmp++; if ({obs_i_done, obs_d_done} !== 2'b10) begin n_bad++; $display("[TB] FAIL simul_second_owner got %b want 10", {obs_i_done, obs_d_done}); end
    n_cmp++; if (done_cyc !== 13) begin n_bad++; $display("[TB] FAIL simul_i_latency got %0d want 13", done_cyc); end
    n_cmp++; if (obs_addr.size() < 1 || obs_addr[0] !== 16'h0010) begin n_bad++; $display("[TB] FAIL simul_i_first_addr got size=%0d want first 0010", obs_addr.size()); end
    n_cmp++; if (obs_i_we !== 8 || obs_d_we !== 0) begin n_bad++; $display("[TB] FAIL simul_i_beats got i=%0d d=%0d want i=8 d=0", obs_i_we, obs_d_we); end
  endtask

  task automatic test_store();
    @(posedge clk); @(negedge clk);
    d_addr = 16'h0042; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_wr} !== 2'b11) begin n_bad++; $display("[TB] FAIL store_en_wr got %b want 11", {mem_en, mem_wr}); end
    n_cmp++; if (mem_addr !== 16'h0042) begin n_bad++; $display("[TB] FAIL store_addr got %h want 0042", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("[TB] FAIL store_wdata got %h want beef", mem_wdata); end
    n_cmp++; if (d_done !== 1'b0) begin n_bad++; $display("[TB] FAIL store_early_done got %b want 0", d_done); end
    @(negedge clk);
    n_cmp++; if ({mem_en, d_done, i_done} !== 3'b010) begin n_bad++; $display("[TB] FAIL store_done got en,d,i=%b want 010", {mem_en, d_done, i_done}); end
    n_cmp++; if ({i_fill_we, d_fill_we} !== 2'b00) begin n_bad++; $display("[TB] FAIL store_fill_we got %b want 00", {i_fill_we, d_fill_we}); end
    d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({busy, mem_en} !== 2'b00) begin n_bad++; $display("[TB] FAIL store_idle_after got %b want 00", {busy, mem_en}); end
  endtask

  task automatic test_no_preempt();
    int  foreign = 0;
    int  idone   = -1;
    bit  raised  = 0;
    @(posedge clk); @(negedge clk);
    i_addr = 16'h2004; i_req = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && idone < 0; cyc++) begin
      @(negedge clk);
      if (mem_en && mem_addr[15:4] !== 12'h200) foreign++;
      if (d_done || d_fill_we) foreign++;
      if (i_done) begin idone = cyc; i_req = 1'b0; end
      if (i_fill_we && fill_word == 3'd2 && !raised) begin
        raised = 1; d_addr = 16'h4000; d_wr = 1'b0; d_req = 1'b1;
      end
    end
    n_cmp++; if (raised !== 1'b1) begin n_bad++; $display("[TB] FAIL nopre_third_beat got raised=%b want 1", raised); end
    n_cmp++; if (foreign !== 0) begin n_bad++; $display("[TB] FAIL nopre_foreign_traffic got %0d want 0", foreign); end
    n_cmp++; if (idone !== 13) begin n_bad++; $display("[TB] FAIL nopre_i_latency got %0d want 13", idone); end
    @(posedge clk);
    @(posedge clk);
    observe(20);
    n_cmp++; if ({obs_i_done, obs_d_done} !== 2'b01) begin n_bad++; $display("[TB] FAIL nopre_d_owner got %b want 01", {obs_i_done, obs_d_done}); end
    n_cmp++; if (obs_addr.size() < 8 || obs_addr[0] !== 16'h4000 || obs_addr[7] !== 16'h400E) begin n_bad++; $display("[TB] FAIL nopre_d_addrs got size=%0d want 8 from 4000 to 400e", obs_addr.size()); end
    n_cmp++; if (done_cyc !== 13) begin n_bad++; $display("[TB] FAIL nopre_d_latency got %0d want 13", done_cyc); end
  endtask

  task automatic test_wrap();
    @(posedge clk); @(negedge clk);
    i_addr = 16'hFFFA; i_req = 1'b1;
    @(posedge clk);
    observe(20);
    n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("[TB] FAIL wrap_issue_count got %0d want 8", obs_addr.size()); end
    for (int k = 0; k < 8 && k < obs_addr.size(); k++) begin
      n_cmp++; if (obs_addr[k] !== 16'hFFF0 + 16'(2*k)) begin n_bad++; $display("[TB] FAIL wrap_addr[%0d] got %h want %h", k, obs_addr[k], 16'hFFF0 + 16'(2*k)); end
    end
    n_cmp++; if (obs_data.size() < 8 || obs_data[7] !== (16'hFFFE ^ 16'hA5A5)) begin n_bad++; $display("[TB] FAIL wrap_last_data got size=%0d want 8 ending %h", obs_data.size(), 16'hFFFE ^ 16'hA5A5); end
    n_cmp++; if (obs_i_done !== 1'b1 || done_cyc !== 13) begin n_bad++; $display("[TB] FAIL wrap_done got done=%b cyc=%0d want 1 13", obs_i_done, done_cyc); end
  endtask

  task automatic test_reset_midfill();
    bit found = 0;
    @(posedge clk); @(negedge clk);
    i_addr = 16'h3000; i_req = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
      @(negedge clk);
      if (i_fill_we && fill_word == 3'd3) found = 1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_fourth_beat got found=%b want 1", found); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if ({mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done} !== 6'b0) begin n_bad++; $display("[TB] FAIL midrst_flags got %b want 000000", {mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done}); end
    n_cmp++; if ({mem_addr, mem_wdata, fill_data} !== 48'h0 || fill_word !== 3'd0) begin n_bad++; $display("[TB] FAIL midrst_buses got addr=%h wdata=%h data=%h word=%0d want all 0", mem_addr, mem_wdata, fill_data, fill_word); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    observe(20);
    n_cmp++; if (obs_i_we !== 8 || obs_word.size() !== 8) begin n_bad++; $display("[TB] FAIL midrst_refill_beats got %0d want 8", obs_i_we); end
    for (int k = 0; k < 8 && k < obs_word.size(); k++) begin
      n_cmp++; if (obs_word[k] !== 3'(k)) begin n_bad++; $display("[TB] FAIL midrst_word[%0d] got %0d want %0d", k, obs_word[k], k); end
    end
    n_cmp++; if (obs_i_done !== 1'b1 || done_cyc !== 13) begin n_bad++; $display("[TB] FAIL midrst_done got done=%b cyc=%0d want 1 13", obs_i_done, done_cyc); end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_i_fill();
    test_simultaneous();
    test_store();
    test_no_preempt();
    test_wrap();
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
